// File: rtl/serial_logic_pkg.sv
// Shared encodings for the serial logic unit: operation select codes and FSM states.
package serial_logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/nand_logic_lane.sv
// One-bit logic lane: AND, OR, XOR and NOT built only from 2-input NAND gates,
// with a 4:1 select on op.
module nand_logic_lane (
    input  logic       x,
    input  logic       y,
    input  logic [1:0] op,
    output logic       r
);
    import serial_logic_pkg::*;

    logic nxy, nx, ny, and_r, or_r, xor_t1, xor_t2, xor_r;

    nand g_nxy (nxy, x, y);
    nand g_nx  (nx, x, x);
    nand g_ny  (ny, y, y);
    nand g_and (and_r, nxy, nxy);
    nand g_or  (or_r, nx, ny);
    // Classic four-NAND XOR sharing the x/y NAND term.
    nand g_xt1 (xor_t1, x, nxy);
    nand g_xt2 (xor_t2, y, nxy);
    nand g_xor (xor_r, xor_t1, xor_t2);

    always_comb begin
        r = 1'b0;
        unique case (op)
            OP_AND:  r = and_r;
            OP_OR:   r = or_r;
            OP_XOR:  r = xor_r;
            OP_NOT:  r = nx;
            default: r = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit: LANES result bits per clock, LSB-first,
// with a start/busy/done handshake and running parity of the result.
module serial_logic_unit
    import serial_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             parity
);

    localparam int unsigned STEPS = WIDTH / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
        $error("serial_logic_unit: WIDTH must be >= 1 and a multiple of LANES");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             parity_q, parity_d;
    logic             load;

    logic [31:0]      shamt;
    logic [LANES-1:0] lane_x, lane_y, lane_r;

    assign shamt  = 32'(cnt_q) * LANES;
    assign lane_x = LANES'(a_q >> shamt);
    assign lane_y = LANES'(b_q >> shamt);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        nand_logic_lane u_lane (
            .x  (lane_x[i]),
            .y  (lane_y[i]),
            .op (op_q),
            .r  (lane_r[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        parity_d = parity_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    cnt_d    = '0;
                    result_d = '0;
                    parity_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Target bits are still zero, so OR-ing the new slice in is a write.
                result_d = result_q | (WIDTH'(lane_r) << shamt);
                parity_d = parity_q ^ (^lane_r);
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            parity_q <= parity_d;
            if (load) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign parity = parity_q;

endmodule
